mips_cpu_multdiv: RTL

Iterative multiply/divide unit owning the architectural HI/LO registers. It sits beside the ALU in the execute stage and takes the same rs_content/rt_content operands from the register file. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes hi/lo for MFHI/MFLO. It is a one-bit-per-cycle radix-2 engine; the control FSM stalls the CPU on busy.

---
 rtl/mips_cpu_multdiv_pkg.sv | 33 +++
 rtl/mips_cpu_multdiv.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mips_cpu_multdiv_pkg.sv
// Shared types and helpers for the iterative HI/LO multiply/divide unit.
package mips_cpu_multdiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return (~v) + (2*XLEN)'(1);
  endfunction

  // Magnitude of a two's-complement value; unsigned operands pass through raw.
  function automatic logic [XLEN-1:0] abs_w(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? neg_w(v) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_multdiv.sv
// Radix-2 multiply/divide engine owning HI/LO: one bit per cycle on magnitudes,
// with sign fix-up applied in a final cycle. WIDTH must equal the package XLEN.
module mips_cpu_multdiv
  import mips_cpu_multdiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e              op_in_s;
  logic             in_signed_s;
  logic             in_div_s;
  logic             run_div_s;
  logic [WIDTH-1:0] rs_mag_s, rt_mag_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // Datapath: one shift-add / trial-subtract step plus final sign correction.
  always_comb begin
    op_in_s     = op_e'(op);
    in_signed_s = (op_in_s == OP_MULT) || (op_in_s == OP_DIV);
    in_div_s    = (op_in_s == OP_DIV) || (op_in_s == OP_DIVU);
    run_div_s   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    rs_mag_s    = abs_w(rs_content, in_signed_s);
    rt_mag_s    = abs_w(rt_content, in_signed_s);
    add_s  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    sub_s  = acc_q[DW-1:WIDTH-1] - {1'b0, mag_q};
    prod_s = neg_res_q ? neg_dw(acc_q) : acc_q;
    // Divide by zero leaves the dividend as remainder, so only LO needs forcing.
    quo_s  = div0_q ? {WIDTH{1'b1}}
                    : (neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
    rem_s  = neg_rem_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
  end

  // Control FSM: next state, operand latch, iteration and HI/LO update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          op_d      = op_in_s;
          neg_res_d = in_signed_s & (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
          neg_rem_d = in_signed_s & rs_content[WIDTH-1];
          div0_d    = in_div_s & (rt_content == {WIDTH{1'b0}});
          mag_d     = in_div_s ? rt_mag_s : rs_mag_s;
          acc_d     = {{WIDTH{1'b0}}, (in_div_s ? rs_mag_s : rt_mag_s)};
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          if (mthi) hi_d = rs_content;
          else      hi_d = hi_q;
          if (mtlo) lo_d = rs_content;
          else      lo_d = lo_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (run_div_s) begin
          acc_d = sub_s[WIDTH] ? {acc_q[DW-2:0], 1'b0}
                               : {sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {add_s, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        else                            state_d = S_RUN;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (run_div_s) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end else begin
          hi_d = prod_s[DW-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mag_q     <= {WIDTH{1'b0}};
      acc_q     <= {DW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
